// File: rtl/acc_reg.sv
// acc_reg: parallel-load accumulator register with async active-low reset.
// Define ACC_STATUS_FLAGS_EN to add the acc_zero / acc_neg decode outputs.
module acc_reg #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic [WIDTH-1:0] acc_in,
  output logic [WIDTH-1:0] acc_out
`ifdef ACC_STATUS_FLAGS_EN
  ,
  output logic             acc_zero,
  output logic             acc_neg
`endif
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) acc_out <= RESET_VALUE;
    else if (ld) acc_out <= acc_in;
`ifdef ACC_STATUS_FLAGS_EN
  // Flags decode the stored value, so they move together with acc_out.
  always_comb begin
    acc_zero = (acc_out == '0);
    acc_neg  = acc_out[WIDTH-1];
  end
`endif
endmodule

// File: tb/tb_acc_reg.sv
// tb_acc_reg: table-driven scoreboard bench for acc_reg.
module tb_acc_reg;
  logic       clk = 0;
  logic       reset = 1;
  logic       ld = 0;
  logic [7:0] acc_in = 0;
  logic [7:0] acc_out;
  int total = 0;
  int bad = 0;
  logic [7:0] q[$];
`ifdef ACC_STATUS_FLAGS_EN
  logic acc_zero, acc_neg;
  acc_reg #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (.clk(clk), .reset(reset), .ld(ld), .acc_in(acc_in), .acc_out(acc_out), .acc_zero(acc_zero), .acc_neg(acc_neg));
`else
  acc_reg #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (.clk(clk), .reset(reset), .ld(ld), .acc_in(acc_in), .acc_out(acc_out));
`endif
  always #5 clk = ~clk;
  typedef struct {
    logic       ld;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[23];
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  initial begin
    vecs = '{
      '{1'b1, 8'h1A, 8'h1A}, '{1'b0, 8'h22, 8'h1A},
      '{1'b1, 8'h22, 8'h22}, '{1'b0, 8'h42, 8'h22},
      '{1'b1, 8'h42, 8'h42}, '{1'b0, 8'h82, 8'h42},
      '{1'b1, 8'h82, 8'h82}, '{1'b0, 8'h84, 8'h82},
      '{1'b1, 8'h84, 8'h84}, '{1'b0, 8'hA6, 8'h84},
      '{1'b1, 8'hA6, 8'hA6}, '{1'b0, 8'h83, 8'hA6},
      '{1'b1, 8'h83, 8'h83}, '{1'b0, 8'h00, 8'h83},
      '{1'b1, 8'h01, 8'h01}, '{1'b1, 8'h02, 8'h02},
      '{1'b1, 8'h04, 8'h04}, '{1'b1, 8'h08, 8'h08},
      '{1'b0, 8'h55, 8'h08}, '{1'b1, 8'h00, 8'h00},
      '{1'b1, 8'h83, 8'h83}, '{1'b0, 8'h7E, 8'h83},
      '{1'b1, 8'hFF, 8'hFF}
    };
    #1;
    ld = 1;
    acc_in = 8'hA6;
    reset = 0;
    #1;
    chk("reset_immediate", acc_out, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_hold_ld", acc_out, 8'h00);
    end
    @(negedge clk);
    reset = 1;
    ld = 0;
    @(posedge clk);
    #1;
    chk("release_no_load", acc_out, 8'h00);
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      ld = vecs[i].ld;
      acc_in = vecs[i].din;
      q.push_back(vecs[i].exp);
      #2 acc_in = vecs[i].din ^ 8'h5A;
      #1 acc_in = vecs[i].din;
      chk("no_comb_path", acc_out, i == 0 ? 8'h00 : vecs[i-1].exp);
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_empty: got 0 entries want 1");
      end else begin
        logic [7:0] e;
        e = q.pop_front();
        chk($sformatf("vec%0d", i), acc_out, e);
`ifdef ACC_STATUS_FLAGS_EN
        chk($sformatf("zero%0d", i), {7'd0, acc_zero}, {7'd0, e == 8'h00});
        chk($sformatf("neg%0d", i), {7'd0, acc_neg}, {7'd0, e[7]});
`endif
      end
    end
    #1;
    ld = 0;
    reset = 0;
    #1;
    chk("async_mid_reset", acc_out, 8'h00);
    @(negedge clk);
    chk("async_reset_held", acc_out, 8'h00);
    reset = 1;
    @(posedge clk);
    #1;
    chk("post_reset_hold", acc_out, 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
